// File: rtl/accel_smoothing_filter.sv
// accel_smoothing_filter: per-axis moving-average filter for raw accelerometer
// samples. It keeps a DEPTH-entry circular history and a running sum per axis,
// and emits the floored window average one clock after each accepted sample.
//
// Ports:
//   clk                     system clock, rising edge
//   reset                   asynchronous active-high reset
//   data_valid              single-cycle strobe, data_x/data_y hold a new sample
//   data_x, data_y          raw signed samples (DATA_W bits)
//   flush                   synchronous clear of filter history (beats data_valid)
//   smoothing_filter_out_x  registered signed X average
//   smoothing_filter_out_y  registered signed Y average
//   out_valid               one-cycle pulse when new averages are presented
//   primed                  high once DEPTH samples accepted since reset/flush
module accel_smoothing_filter #(
  parameter int unsigned LOG2_DEPTH = 3,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_x,
  input  logic [DATA_W-1:0] data_y,
  input  logic              flush,
  output logic [DATA_W-1:0] smoothing_filter_out_x,
  output logic [DATA_W-1:0] smoothing_filter_out_y,
  output logic              out_valid,
  output logic              primed
);

  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;
  localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;
  localparam int unsigned CNT_W = LOG2_DEPTH + 1;

  logic signed [DATA_W-1:0] hist_x [DEPTH];
  logic signed [DATA_W-1:0] hist_y [DEPTH];
  logic signed [SUM_W-1:0]  sum_x;
  logic signed [SUM_W-1:0]  sum_y;
  logic signed [SUM_W-1:0]  sum_x_nx;
  logic signed [SUM_W-1:0]  sum_y_nx;
  logic [LOG2_DEPTH-1:0]    ptr;
  logic [CNT_W-1:0]         fill;
  logic [CNT_W-1:0]         fill_nx;

  // Running-sum update: add the new sample, drop the one it overwrites.
  always_comb begin
    sum_x_nx = sum_x + SUM_W'(signed'(data_x)) - SUM_W'(hist_x[ptr]);
    sum_y_nx = sum_y + SUM_W'(signed'(data_y)) - SUM_W'(hist_y[ptr]);
    fill_nx  = (fill == CNT_W'(DEPTH)) ? fill : fill + CNT_W'(1);
  end

  // History, sums, pointer, fill count and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist_x[i] <= '0;
        hist_y[i] <= '0;
      end
      sum_x                  <= '0;
      sum_y                  <= '0;
      ptr                    <= '0;
      fill                   <= '0;
      smoothing_filter_out_x <= '0;
      smoothing_filter_out_y <= '0;
      out_valid              <= 1'b0;
      primed                 <= 1'b0;
    end else if (flush) begin
      // Flush discards any simultaneous sample.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        hist_x[i] <= '0;
        hist_y[i] <= '0;
      end
      sum_x                  <= '0;
      sum_y                  <= '0;
      ptr                    <= '0;
      fill                   <= '0;
      smoothing_filter_out_x <= '0;
      smoothing_filter_out_y <= '0;
      out_valid              <= 1'b0;
      primed                 <= 1'b0;
    end else if (data_valid) begin
      hist_x[ptr]            <= signed'(data_x);
      hist_y[ptr]            <= signed'(data_y);
      sum_x                  <= sum_x_nx;
      sum_y                  <= sum_y_nx;
      ptr                    <= ptr + LOG2_DEPTH'(1);
      fill                   <= fill_nx;
      // Arithmetic shift floors toward minus infinity; the quotient fits DATA_W.
      smoothing_filter_out_x <= DATA_W'(sum_x_nx >>> LOG2_DEPTH);
      smoothing_filter_out_y <= DATA_W'(sum_y_nx >>> LOG2_DEPTH);
      out_valid              <= 1'b1;
      primed                 <= (fill_nx == CNT_W'(DEPTH));
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
